// File: rtl/intersection_pkg.sv
// Shared types for the two-approach intersection scheduler: states, lamp encodings, approach ids.
// Optional FLASH_MODE_EN adds the FLASH state.
package intersection_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_ALL_RED,
    ST_A_GREEN,
    ST_A_YELLOW,
    ST_B_GREEN,
    ST_B_YELLOW,
    ST_PED_WALK
`ifdef FLASH_MODE_EN
    , ST_FLASH
`endif
  } state_t;

  typedef enum logic {APPR_A, APPR_B} approach_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       walk;
  } lamps_t;

  // Lamp pattern shown on entry to each state; anything unlisted is all-red.
  function automatic lamps_t lamps_of(state_t s);
    lamps_t l;
    l.a    = LIGHT_RED;
    l.b    = LIGHT_RED;
    l.walk = 1'b0;
    case (s)
      ST_A_GREEN:  l.a = LIGHT_GREEN;
      ST_A_YELLOW: l.a = LIGHT_YELLOW;
      ST_B_GREEN:  l.b = LIGHT_GREEN;
      ST_B_YELLOW: l.b = LIGHT_YELLOW;
      ST_PED_WALK: l.walk = 1'b1;
`ifdef FLASH_MODE_EN
      ST_FLASH: begin
        l.a = LIGHT_YELLOW;
        l.b = LIGHT_YELLOW;
      end
`endif
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_second_tick_gen.sv
// 1 s tick prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
module second_tick_gen
  import intersection_pkg::*;
#(
  parameter int TICK_DIV = 24_000_000
) (
  input  logic sayac,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous active-low.
  always_ff @(posedge sayac or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection controller arbitrating green between A, B and a pedestrian walk.
// Define FLASH_MODE_EN to add the flash_en input and the flashing-yellow FLASH state.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int TICK_DIV  = 24_000_000,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int PED_T     = 8
) (
  input  logic       sayac,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_req,
`ifdef FLASH_MODE_EN
  input  logic       flash_en,
`endif
  output logic [2:0] lights_a,
  output logic [2:0] lights_b,
  output logic       walk,
  output logic       ped_pending,
  output logic       tick
);

  state_t               state;
  approach_t            next_green;
  lamps_t               lamps;
  logic [TIMER_W-1:0]   sec_timer;
  logic [TIMER_W-1:0]   elapsed;
  logic [TIMER_W-1:0]   elapsed_inc;
  logic                 own_req;
  logic                 other_req;
  logic                 green_done;

  second_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .sayac (sayac),
    .reset (reset),
    .tick  (tick)
  );

  // Decision is taken on the elapsed value this tick will produce, so green lasts exactly GREEN_MIN ticks.
  always_comb begin
    elapsed_inc = (elapsed >= TIMER_W'(GREEN_MAX)) ? TIMER_W'(GREEN_MAX) : elapsed + 1'b1;
    own_req     = (state == ST_B_GREEN) ? req_b : req_a;
    other_req   = (state == ST_B_GREEN) ? req_a : req_b;
    green_done  = (elapsed_inc >= TIMER_W'(GREEN_MIN)) && (other_req || ped_pending) &&
                  ((elapsed_inc >= TIMER_W'(GREEN_MAX)) || !own_req);
  end

  always_ff @(posedge sayac or negedge reset) begin
    if (!reset) begin
      state       <= ST_ALL_RED;
      next_green  <= APPR_A;
      sec_timer   <= TIMER_W'(ALLRED_T);
      elapsed     <= '0;
      lamps       <= lamps_of(ST_ALL_RED);
      ped_pending <= 1'b0;
    end else begin
      // NOTE: the PED_WALK-entry clear below is written later, so it overrides this set in the same cycle.
      if (ped_req && (state != ST_PED_WALK)) ped_pending <= 1'b1;

      if (tick) begin
`ifdef FLASH_MODE_EN
        if (flash_en && (state != ST_FLASH)) begin
          state <= ST_FLASH;
          lamps <= lamps_of(ST_FLASH);
        end else
`endif
        case (state)
          ST_ALL_RED: begin
            if (sec_timer > TIMER_W'(1)) begin
              sec_timer <= sec_timer - 1'b1;
            end else if (ped_pending) begin
              state       <= ST_PED_WALK;
              sec_timer   <= TIMER_W'(PED_T);
              lamps       <= lamps_of(ST_PED_WALK);
              ped_pending <= 1'b0;
            end else begin
              state     <= (next_green == APPR_A) ? ST_A_GREEN : ST_B_GREEN;
              lamps     <= lamps_of((next_green == APPR_A) ? ST_A_GREEN : ST_B_GREEN);
              sec_timer <= '0;
              elapsed   <= '0;
            end
          end
          ST_A_GREEN, ST_B_GREEN: begin
            if (green_done) begin
              state     <= (state == ST_A_GREEN) ? ST_A_YELLOW : ST_B_YELLOW;
              lamps     <= lamps_of((state == ST_A_GREEN) ? ST_A_YELLOW : ST_B_YELLOW);
              sec_timer <= TIMER_W'(YELLOW_T);
            end else begin
              elapsed <= elapsed_inc;
            end
          end
          ST_A_YELLOW, ST_B_YELLOW: begin
            if (sec_timer > TIMER_W'(1)) begin
              sec_timer <= sec_timer - 1'b1;
            end else begin
              state      <= ST_ALL_RED;
              next_green <= (state == ST_A_YELLOW) ? APPR_B : APPR_A;
              sec_timer  <= TIMER_W'(ALLRED_T);
              lamps      <= lamps_of(ST_ALL_RED);
            end
          end
          ST_PED_WALK: begin
            if (sec_timer > TIMER_W'(1)) begin
              sec_timer <= sec_timer - 1'b1;
            end else begin
              state     <= ST_ALL_RED;
              sec_timer <= TIMER_W'(ALLRED_T);
              lamps     <= lamps_of(ST_ALL_RED);
            end
          end
`ifdef FLASH_MODE_EN
          ST_FLASH: begin
            if (!flash_en) begin
              state      <= ST_ALL_RED;
              next_green <= APPR_A;
              sec_timer  <= TIMER_W'(ALLRED_T);
              lamps      <= lamps_of(ST_ALL_RED);
            end else begin
              lamps.a <= lamps.a ^ LIGHT_YELLOW;
              lamps.b <= lamps.b ^ LIGHT_YELLOW;
            end
          end
`endif
          default: begin
            state     <= ST_ALL_RED;
            sec_timer <= TIMER_W'(ALLRED_T);
            lamps     <= lamps_of(ST_ALL_RED);
          end
        endcase
      end
    end
  end

  assign lights_a = lamps.a;
  assign lights_b = lamps.b;
  assign walk     = lamps.walk;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with a 4-cycle tick; FLASH_MODE_EN enables the flash scenario.
module tb_intersection_phase_scheduler;

  localparam int TICK_DIV = 4;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic sayac = 1'b0;
  logic reset = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic ped_req = 1'b0;
`ifdef FLASH_MODE_EN
  logic flash_en = 1'b0;
`endif
  logic [2:0] lights_a, lights_b;
  logic walk, ped_pending, tick;

  int checks = 0;
  int errors = 0;
  int inv_viol = 0;

  always #5 sayac = ~sayac;

  intersection_phase_scheduler #(.TICK_DIV(TICK_DIV)) dut (
    .sayac       (sayac),
    .reset       (reset),
    .req_a       (req_a),
    .req_b       (req_b),
    .ped_req     (ped_req),
`ifdef FLASH_MODE_EN
    .flash_en    (flash_en),
`endif
    .lights_a    (lights_a),
    .lights_b    (lights_b),
    .walk        (walk),
    .ped_pending (ped_pending),
    .tick        (tick)
  );

  // Mutual exclusion monitor; the flash pattern is the only legal both-yellow case.
  logic flash_pair;
`ifdef FLASH_MODE_EN
  assign flash_pair = (lights_a == Y) && (lights_b == Y);
`else
  assign flash_pair = 1'b0;
`endif
  always @(negedge sayac) begin
    if (reset) begin
      if (((|lights_a[1:0]) && (|lights_b[1:0]) && !flash_pair) ||
          (((|lights_a[1:0]) || (|lights_b[1:0])) && walk))
        inv_viol++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Wait for the next tick pulse, then return at the negedge after the update edge.
  task automatic next_tick();
    int n = 0;
    while (tick !== 1'b1) begin
      if (n == 4 * TICK_DIV) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout: no tick within %0d cycles", n);
        return;
      end
      @(negedge sayac);
      n++;
    end
    @(negedge sayac);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    ped_req = 1'b0;
`ifdef FLASH_MODE_EN
    flash_en = 1'b0;
`endif
    repeat (2) @(negedge sayac);
    reset = 1'b1;
    next_tick();
    next_tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge sayac);
    checks++;
    if ({lights_a, lights_b, walk, ped_pending, tick} !== {R, R, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", {lights_a, lights_b, walk, ped_pending, tick},
               {R, R, 1'b0, 1'b0, 1'b0});
    end
    reset = 1'b1;
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, R, 1'b0}) begin
      errors++;
      $display("FAIL allred_tick1: got %b want %b", {lights_a, lights_b, walk}, {R, R, 1'b0});
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {G, R, 1'b0}) begin
      errors++;
      $display("FAIL a_green_entry: got %b want %b", {lights_a, lights_b, walk}, {G, R, 1'b0});
    end
    for (int i = 0; i < 40; i++) begin
      next_tick();
      checks++;
      if ({lights_a, lights_b, walk} !== {G, R, 1'b0}) begin
        errors++;
        $display("FAIL a_green_rest tick %0d: got %b want %b", i, {lights_a, lights_b, walk}, {G, R, 1'b0});
      end
    end
  endtask

  task automatic test_max_green();
    do_reset();
    req_a = 1'b1;
    next_tick();
    next_tick();
    req_b = 1'b1;
    for (int e = 3; e < 30; e++) begin
      next_tick();
      checks++;
      if ({lights_a, lights_b, walk} !== {G, R, 1'b0}) begin
        errors++;
        $display("FAIL max_green_hold e=%0d: got %b want %b", e, {lights_a, lights_b, walk}, {G, R, 1'b0});
      end
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {Y, R, 1'b0}) begin
      errors++;
      $display("FAIL max_green_yellow: got %b want %b", {lights_a, lights_b, walk}, {Y, R, 1'b0});
    end
    repeat (2) next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {Y, R, 1'b0}) begin
      errors++;
      $display("FAIL yellow_hold: got %b want %b", {lights_a, lights_b, walk}, {Y, R, 1'b0});
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, R, 1'b0}) begin
      errors++;
      $display("FAIL yellow_to_allred: got %b want %b", {lights_a, lights_b, walk}, {R, R, 1'b0});
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, R, 1'b0}) begin
      errors++;
      $display("FAIL allred_hold: got %b want %b", {lights_a, lights_b, walk}, {R, R, 1'b0});
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, G, 1'b0}) begin
      errors++;
      $display("FAIL b_green_after_a: got %b want %b", {lights_a, lights_b, walk}, {R, G, 1'b0});
    end
  endtask

  task automatic test_min_green();
    do_reset();
    req_b = 1'b1;
    for (int e = 1; e < 10; e++) begin
      next_tick();
      checks++;
      if ({lights_a, lights_b, walk} !== {G, R, 1'b0}) begin
        errors++;
        $display("FAIL min_green_hold e=%0d: got %b want %b", e, {lights_a, lights_b, walk}, {G, R, 1'b0});
      end
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {Y, R, 1'b0}) begin
      errors++;
      $display("FAIL min_green_switch: got %b want %b", {lights_a, lights_b, walk}, {Y, R, 1'b0});
    end
    repeat (5) next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, G, 1'b0}) begin
      errors++;
      $display("FAIL min_green_b_green: got %b want %b", {lights_a, lights_b, walk}, {R, G, 1'b0});
    end
  endtask

  // Runs from B green entry left by test_min_green.
  task automatic test_ped_walk();
    req_a = 1'b0;
    req_b = 1'b0;
    next_tick();
    next_tick();
    ped_req = 1'b1;
    @(negedge sayac);
    ped_req = 1'b0;
    checks++;
    if (ped_pending !== 1'b1) begin
      errors++;
      $display("FAIL ped_latched: got %b want 1", ped_pending);
    end
    for (int e = 3; e < 10; e++) begin
      next_tick();
      checks++;
      if ({lights_a, lights_b, walk} !== {R, G, 1'b0}) begin
        errors++;
        $display("FAIL ped_b_hold e=%0d: got %b want %b", e, {lights_a, lights_b, walk}, {R, G, 1'b0});
      end
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, Y, 1'b0}) begin
      errors++;
      $display("FAIL ped_b_yellow: got %b want %b", {lights_a, lights_b, walk}, {R, Y, 1'b0});
    end
    repeat (4) next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, R, 1'b0}) begin
      errors++;
      $display("FAIL ped_allred: got %b want %b", {lights_a, lights_b, walk}, {R, R, 1'b0});
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk, ped_pending} !== {R, R, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL walk_entry: got %b want %b", {lights_a, lights_b, walk, ped_pending}, {R, R, 1'b1, 1'b0});
    end
    ped_req = 1'b1;
    @(negedge sayac);
    ped_req = 1'b0;
    checks++;
    if (ped_pending !== 1'b0) begin
      errors++;
      $display("FAIL ped_ignored_in_walk: got %b want 0", ped_pending);
    end
    for (int t = 1; t < 8; t++) begin
      next_tick();
      checks++;
      if ({lights_a, lights_b, walk} !== {R, R, 1'b1}) begin
        errors++;
        $display("FAIL walk_hold t=%0d: got %b want %b", t, {lights_a, lights_b, walk}, {R, R, 1'b1});
      end
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, R, 1'b0}) begin
      errors++;
      $display("FAIL walk_end: got %b want %b", {lights_a, lights_b, walk}, {R, R, 1'b0});
    end
    repeat (2) next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {G, R, 1'b0}) begin
      errors++;
      $display("FAIL walk_then_a_green: got %b want %b", {lights_a, lights_b, walk}, {G, R, 1'b0});
    end
  endtask

  task automatic test_reset_midphase();
    do_reset();
    req_b = 1'b1;
    repeat (15) next_tick();
    req_a = 1'b1;
    req_b = 1'b0;
    repeat (10) next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {R, Y, 1'b0}) begin
      errors++;
      $display("FAIL mid_b_yellow: got %b want %b", {lights_a, lights_b, walk}, {R, Y, 1'b0});
    end
    next_tick();
    @(negedge sayac);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({lights_a, lights_b, walk, tick} !== {R, R, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_abort: got %b want %b", {lights_a, lights_b, walk, tick}, {R, R, 1'b0, 1'b0});
    end
    @(negedge sayac);
    reset = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge sayac);
      checks++;
      if (tick !== (c == 3)) begin
        errors++;
        $display("FAIL prescaler_restart cycle %0d: got %b want %b", c, tick, (c == 3));
      end
    end
    @(negedge sayac);
    checks++;
    if ({lights_a, lights_b, walk} !== {R, R, 1'b0}) begin
      errors++;
      $display("FAIL restart_allred: got %b want %b", {lights_a, lights_b, walk}, {R, R, 1'b0});
    end
    next_tick();
    checks++;
    if ({lights_a, lights_b, walk} !== {G, R, 1'b0}) begin
      errors++;
      $display("FAIL restart_a_green: got %b want %b", {lights_a, lights_b, walk}, {G, R, 1'b0});
    end
  endtask

`ifdef FLASH_MODE_EN
  task automatic test_flash();
    logic [6:0] exp_seq [6];
    exp_seq[0] = {Y, Y, 1'b0};
    exp_seq[1] = {O, O, 1'b0};
    exp_seq[2] = {Y, Y, 1'b0};
    exp_seq[3] = {R, R, 1'b0};
    exp_seq[4] = {R, R, 1'b0};
    exp_seq[5] = {G, R, 1'b0};
    do_reset();
    flash_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) flash_en = 1'b0;
      next_tick();
      checks++;
      if ({lights_a, lights_b, walk} !== exp_seq[i]) begin
        errors++;
        $display("FAIL flash step %0d: got %b want %b", i, {lights_a, lights_b, walk}, exp_seq[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_max_green();
    test_min_green();
    test_ped_walk();
    test_reset_midphase();
`ifdef FLASH_MODE_EN
    test_flash();
`endif
    checks++;
    if (inv_viol != 0) begin
      errors++;
      $display("FAIL exclusion_invariant: got %0d violating cycles want 0", inv_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
